// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: dispatcher states and byte width.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_ISSUE = 2'd1,
        D_WAIT  = 2'd2
    } disp_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers/count and combinational head read.
// Push is refused when full and pop when empty, so callers may drive them freely.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == {(AW+1){1'b0}});
    assign full      = (count_r == FULL_CNT);
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus dispatcher feeding uart_tx over tx_start/tx_active/tx_done.
// Define UART_TX_FIFO_OVERFLOW_EN to add the sticky overflow flag and its clear input.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid_in,
    input  logic [BYTE_W-1:0]      wr_data_in,
    output logic                   wr_ready_out,
    output logic                   tx_start_out,
    output logic [BYTE_W-1:0]      tx_byte_out,
    input  logic                   tx_active_in,
    input  logic                   tx_done_in,
`ifdef UART_TX_FIFO_OVERFLOW_EN
    output logic                   overflow_out,
    input  logic                   overflow_clr_in,
`endif
    output logic [$clog2(DEPTH):0] count_out,
    output logic                   empty_out,
    output logic                   full_out,
    output logic                   busy_out
);

    disp_state_t       state_r;
    disp_state_t       state_next_s;
    logic [BYTE_W-1:0] byte_r;
    logic [BYTE_W-1:0] head_s;
    logic              start_r;
    logic              pop_s;
    logic              push_s;
    logic              empty_s;
    logic              full_s;

    assign wr_ready_out = rst && !full_s;
    assign push_s       = wr_valid_in && wr_ready_out;
    assign empty_out    = empty_s;
    assign full_out     = full_s;
    assign busy_out     = (state_r != D_IDLE) || !empty_s;
    assign tx_start_out = start_r;
    assign tx_byte_out  = byte_r;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (wr_data_in),
        .rd_data (head_s),
        .count   (count_out),
        .empty   (empty_s),
        .full    (full_s)
    );

    // Dispatcher next-state: pop on leaving idle, hold start until uart_tx reports active.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            D_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = D_ISSUE;
                end else begin
                    state_next_s = D_IDLE;
                end
            end
            D_ISSUE: begin
                if (tx_active_in) state_next_s = D_WAIT;
                else              state_next_s = D_ISSUE;
            end
            D_WAIT: begin
                if (tx_done_in) state_next_s = D_IDLE;
                else            state_next_s = D_WAIT;
            end
            default: state_next_s = D_IDLE;
        endcase
    end

    // State, byte latch and start register; start mirrors the registered D_ISSUE state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= D_IDLE;
            byte_r  <= {BYTE_W{1'b0}};
            start_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            start_r <= (state_next_s == D_ISSUE);
            if (pop_s) byte_r <= head_s;
        end
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic overflow_r;
    assign overflow_out = overflow_r;

    // Sticky overflow: a rejected write sets it, and set wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst)                          overflow_r <= 1'b0;
        else if (wr_valid_in && full_s)    overflow_r <= 1'b1;
        else if (overflow_clr_in)          overflow_r <= 1'b0;
        else                               overflow_r <= overflow_r;
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; the uart_tx handshake is driven by hand.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       busy;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic       overflow;
    logic       ovf_clr;
`endif

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid_in  (wr_valid),
        .wr_data_in   (wr_data),
        .wr_ready_out (wr_ready),
        .tx_start_out (tx_start),
        .tx_byte_out  (tx_byte),
        .tx_active_in (tx_active),
        .tx_done_in   (tx_done),
`ifdef UART_TX_FIFO_OVERFLOW_EN
        .overflow_out    (overflow),
        .overflow_clr_in (ovf_clr),
`endif
        .count_out    (count),
        .empty_out    (empty),
        .full_out     (full),
        .busy_out     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Complete the in-flight frame with a done pulse, optionally pushing during the pop cycle,
    // then expect the next byte to be issued two cycles after done.
    task automatic finish_next(input logic [7:0] exp_byte, input logic wr_en,
                               input logic [7:0] wd, input int exp_cnt);
        tx_done   = 1'b1;
        tx_active = 1'b0;
        step();
        tx_done  = 1'b0;
        wr_valid = wr_en;
        wr_data  = wd;
        chk("gap_start_low", 32'(tx_start), 32'd0);
        step();
        wr_valid = 1'b0;
        chk("next_start", 32'(tx_start), 32'd1);
        chk("next_byte", 32'(tx_byte), 32'(exp_byte));
        chk("count_after_pop", 32'(count), 32'(exp_cnt));
        step();
        tx_active = 1'b1;
        step();
        chk("start_drop", 32'(tx_start), 32'd0);
        chk("byte_stable", 32'(tx_byte), 32'(exp_byte));
    endtask

    initial begin
        rst       = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        tx_active = 1'b0;
        tx_done   = 1'b0;
`ifdef UART_TX_FIFO_OVERFLOW_EN
        ovf_clr   = 1'b0;
`endif
        step();
        step();
        chk("rst_ready", 32'(wr_ready), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_byte", 32'(tx_byte), 32'h00);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
        chk("rst_overflow", 32'(overflow), 32'd0);
`endif
        rst = 1'b1;
        #1;
        chk("ready_after_rst", 32'(wr_ready), 32'd1);

        // First byte: accept in cycle 0, start during cycle 2.
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        step();
        wr_valid = 1'b0;
        chk("c1_count", 32'(count), 32'd1);
        chk("c1_start", 32'(tx_start), 32'd0);
        chk("c1_busy", 32'(busy), 32'd1);
        step();
        chk("c2_start", 32'(tx_start), 32'd1);
        chk("c2_byte", 32'(tx_byte), 32'hA5);
        chk("c2_count", 32'(count), 32'd0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("stray_done_ignored", 32'(tx_start), 32'd1);
        tx_active = 1'b1;
        step();
        chk("c4_start", 32'(tx_start), 32'd0);
        chk("c4_byte", 32'(tx_byte), 32'hA5);

        // Fill to DEPTH while the first byte is on the line.
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h10 + 8'(i);
            step();
        end
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(wr_ready), 32'd0);
        wr_data = 8'hEE;
        step();
        chk("held_count", 32'(count), 32'd16);
`ifdef UART_TX_FIFO_OVERFLOW_EN
        chk("ovf_set", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
`endif
        step();
        wr_valid = 1'b0;
        chk("held2_count", 32'(count), 32'd16);
`ifdef UART_TX_FIFO_OVERFLOW_EN
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        step();
        chk("ovf_cleared", 32'(overflow), 32'd0);
        ovf_clr = 1'b0;
`endif

        // Drain all sixteen buffered bytes in order; rejected 0xEE must never appear.
        for (int k = 0; k < 16; k++) begin
            finish_next(8'h10 + 8'(k), 1'b0, 8'h00, 15 - k);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Push on the pop cycle with three entries queued.
        for (int j = 0; j < 3; j++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h31 + 8'(j);
            step();
        end
        wr_valid = 1'b0;
        chk("pp_pre_count", 32'(count), 32'd3);
        finish_next(8'h31, 1'b1, 8'h34, 3);
        finish_next(8'h32, 1'b0, 8'h00, 2);
        finish_next(8'h33, 1'b0, 8'h00, 1);
        finish_next(8'h34, 1'b0, 8'h00, 0);

        // Back-to-back 0x00 then 0xFF.
        wr_valid = 1'b1;
        wr_data  = 8'h00;
        step();
        wr_data  = 8'hFF;
        step();
        wr_valid = 1'b0;
        finish_next(8'h00, 1'b0, 8'h00, 1);
        finish_next(8'hFF, 1'b0, 8'h00, 0);

        // Reset mid-frame with two bytes still queued.
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        step();
        wr_data  = 8'h66;
        step();
        wr_valid = 1'b0;
        chk("mid_count", 32'(count), 32'd2);
        rst = 1'b0;
        step();
        chk("mr_start", 32'(tx_start), 32'd0);
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_ready", 32'(wr_ready), 32'd0);
        chk("mr_byte", 32'(tx_byte), 32'h00);
        rst       = 1'b1;
        tx_active = 1'b0;
        tx_done   = 1'b1;
        for (int m = 0; m < 4; m++) begin
            step();
            tx_done = 1'b0;
            chk("post_rst_start", 32'(tx_start), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
